// File: rtl/obstacle_if.sv
// Control/status bundle between the game FSM (master) and the obstacle engine (slave).
interface obstacle_if;
    logic        reset_game;
    logic        ld_game;
    logic        calc_jump;
    logic        create_obs;
    logic        ld_pause;
    logic [15:0] height;
    logic        gen;
    logic        kill;
    logic [1:0]  obsValid;
    logic [9:0]  obsX0;
    logic [9:0]  obsX1;
    logic [15:0] score;

    modport master (
        output reset_game, ld_game, calc_jump, create_obs, ld_pause, height,
        input  gen, kill, obsValid, obsX0, obsX1, score
    );

    modport slave (
        input  reset_game, ld_game, calc_jump, create_obs, ld_pause, height,
        output gen, kill, obsValid, obsX0, obsX1, score
    );
endinterface

// File: rtl/obstacle_engine.sv
// Two-slot scrolling obstacle generator with spawn handshake, collision flag and score.
// Every output comes straight from a register.
module obstacle_engine #(
    parameter int unsigned CLOCK_FREQUENCY = 25000000,
    parameter int unsigned SCROLL_HZ       = 60,
    parameter int unsigned SPEED           = 2,
    parameter int unsigned SPAWN_X         = 639,
    parameter int unsigned MIN_GAP         = 40,
    parameter int unsigned DINO_X0         = 40,
    parameter int unsigned DINO_X1         = 60,
    parameter int unsigned OBS_W           = 10,
    parameter int unsigned OBS_TOP         = 90
) (
    input  logic       clk_i,
    input  logic       reset_i,
    obstacle_if.slave  bus
);
    localparam int unsigned TICK_DIV = CLOCK_FREQUENCY / SCROLL_HZ;
    localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W    = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(MIN_GAP);
    localparam logic [9:0]       SPEED_V    = 10'(SPEED);
    localparam logic [9:0]       SPAWN_V    = 10'(SPAWN_X);
    localparam logic [9:0]       DINO_X1_V  = 10'(DINO_X1);
    localparam logic [10:0]      DINO_X0_V  = 11'(DINO_X0);
    localparam logic [10:0]      OBS_W_M1   = 11'(OBS_W - 1);
    localparam logic [15:0]      OBS_TOP_V  = 16'(OBS_TOP);
    localparam logic [15:0]      LFSR_SEED  = 16'hACE1;
    localparam logic [15:0]      LFSR_TAPS  = 16'hB400;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } spawn_state_e;

    spawn_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [15:0]      score_q, score_d;
    logic [1:0]       valid_q, valid_d;
    logic [1:0][9:0]  x_q, x_d;
    logic             kill_q, kill_d;

    logic        running;
    logic        tick;
    logic        accept;
    logic        any_free;
    logic        hit;
    logic [10:0] right_edge;

    // Pause has no effect beyond not being one of the running strobes.
    logic unused_pause;
    assign unused_pause = bus.ld_pause;

    // Next-state logic for the spawn FSM and the slot/score datapath.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        score_d    = score_q;
        valid_d    = valid_q;
        x_d        = x_q;
        kill_d     = kill_q;
        hit        = 1'b0;
        right_edge = 11'd0;

        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        running = bus.ld_game | bus.calc_jump | bus.create_obs;
        tick    = running && (cnt_q == CNT_LAST);
        accept  = bus.create_obs && (state_q == ST_REQ);
        any_free = ~(&valid_q);

        for (int i = 0; i < 2; i++) begin
            right_edge = {1'b0, x_q[i]} + OBS_W_M1;
            if (valid_q[i] && (x_q[i] <= DINO_X1_V) && (right_edge >= DINO_X0_V)
                && (bus.height > OBS_TOP_V)) begin
                hit = 1'b1;
            end
        end

        if (running) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        if (tick) begin
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
            if (gap_q != GAP_MAX)    gap_d   = gap_q + GAP_W'(1);
            for (int i = 0; i < 2; i++) begin
                if (valid_q[i]) begin
                    if (x_q[i] >= SPEED_V) begin
                        x_d[i] = x_q[i] - SPEED_V;
                    end else begin
                        x_d[i]     = 10'd0;
                        valid_d[i] = 1'b0;
                    end
                end
            end
        end

        // A fresh spawn overrides the scroll for its own slot only.
        if (accept) begin
            gap_d = '0;
            if (!valid_q[0]) begin
                valid_d[0] = 1'b1;
                x_d[0]     = SPAWN_V;
            end else begin
                valid_d[1] = 1'b1;
                x_d[1]     = SPAWN_V;
            end
        end

        if (running && hit) kill_d = 1'b1;

        case (state_q)
            ST_IDLE: if (tick && (gap_q == GAP_MAX) && (lfsr_q[3:0] == 4'h0) && any_free)
                         state_d = ST_REQ;
            ST_REQ:  if (bus.create_obs) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Game restart wins over everything except the free-running LFSR.
        if (bus.reset_game) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            gap_d   = '0;
            score_d = 16'd0;
            valid_d = 2'b00;
            x_d     = '0;
            kill_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            score_q <= 16'd0;
            valid_q <= 2'b00;
            x_q     <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
            score_q <= score_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            kill_q  <= kill_d;
        end
    end

    assign bus.gen      = (state_q == ST_REQ);
    assign bus.kill     = kill_q;
    assign bus.obsValid = valid_q;
    assign bus.obsX0    = x_q[0];
    assign bus.obsX1    = x_q[1];
    assign bus.score    = score_q;
endmodule

// File: tb/tb_obstacle_engine.sv
// Bench for obstacle_engine: directed scenarios plus random strobes, all compared
// cycle by cycle against a plain-integer model of the game rules.
module tb_obstacle_engine;
    localparam int TICK_DIV = 10;
    localparam int MIN_GAP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obstacle_if bus ();

    obstacle_engine #(
        .CLOCK_FREQUENCY(600),
        .SCROLL_HZ      (60),
        .MIN_GAP        (MIN_GAP)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state, kept as plain integers.
    int m_cnt, m_score, m_gap, m_lfsr;
    bit m_gen, m_kill;
    bit m_v[2];
    int m_x[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit rg, input bit lg, input bit cj, input bit co,
                         input bit lp, input int h);
        bus.reset_game = rg;
        bus.ld_game    = lg;
        bus.calc_jump  = cj;
        bus.create_obs = co;
        bus.ld_pause   = lp;
        bus.height     = 16'(h);
    endtask

    // Applies the game rules for one clock to the model, using the inputs now driven.
    task automatic model_step();
        int ol;
        bit run, tick, hit, acc, ok;
        int idx;
        ol = m_lfsr;
        if (rst) begin
            m_cnt = 0; m_score = 0; m_gap = 0; m_lfsr = 'hACE1;
            m_gen = 0; m_kill = 0;
            m_v[0] = 0; m_v[1] = 0; m_x[0] = 0; m_x[1] = 0;
            return;
        end
        m_lfsr = (ol % 2 == 1) ? ((ol / 2) ^ 'hB400) : (ol / 2);
        if (bus.reset_game) begin
            m_cnt = 0; m_score = 0; m_gap = 0; m_gen = 0; m_kill = 0;
            m_v[0] = 0; m_v[1] = 0; m_x[0] = 0; m_x[1] = 0;
            return;
        end
        run = bus.ld_game || bus.calc_jump || bus.create_obs;
        if (!run) return;
        tick  = (m_cnt == TICK_DIV - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        hit = 0;
        for (int i = 0; i < 2; i++)
            if (m_v[i] && m_x[i] <= 60 && m_x[i] + 9 >= 40 && int'(bus.height) > 90) hit = 1;
        acc = bus.create_obs && m_gen;
        ok  = tick && m_gap == MIN_GAP && (ol % 16) == 0 && !(m_v[0] && m_v[1]) && !m_gen;
        idx = m_v[0] ? 1 : 0;
        if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (m_v[i]) begin
                    if (m_x[i] >= 2) m_x[i] = m_x[i] - 2;
                    else begin m_v[i] = 0; m_x[i] = 0; end
                end
            end
            if (m_score < 65535) m_score++;
            if (m_gap < MIN_GAP) m_gap++;
        end
        if (acc) begin
            m_v[idx] = 1; m_x[idx] = 639; m_gap = 0; m_gen = 0;
        end
        if (ok)  m_gen = 1;
        if (hit) m_kill = 1;
    endtask

    // One clock: predict, let the DUT clock, then compare all outputs on the falling edge.
    task automatic cycle();
        logic [39:0] act, exp;
        model_step();
        @(posedge clk);
        @(negedge clk);
        act = {bus.gen, bus.kill, bus.obsValid, bus.obsX0, bus.obsX1, bus.score};
        exp = {m_gen, m_kill, m_v[1], m_v[0], 10'(m_x[0]), 10'(m_x[1]), 16'(m_score)};
        check_eq("state", 64'(act), 64'(exp));
    endtask

    task automatic run_until_gen(input int h);
        for (int n = 0; n < 3000 && !m_gen; n++) begin
            drive(0, 1, 0, 0, 0, h);
            cycle();
        end
    endtask

    task automatic spawn(input int h);
        run_until_gen(h);
        check_eq("gen_up", bus.gen, 1);
        drive(0, 1, 0, 1, 0, h);
        cycle();
    endtask

    int sv_score, sv_x0, sv_x1, sv_v;
    bit co;
    int sel, h;

    initial begin
        drive(0, 0, 0, 0, 0, 110);
        rst = 1'b1;
        repeat (3) cycle();
        check_eq("rst_gen", bus.gen, 0);
        check_eq("rst_kill", bus.kill, 0);
        check_eq("rst_valid", bus.obsValid, 0);
        check_eq("rst_x0", bus.obsX0, 0);
        check_eq("rst_x1", bus.obsX1, 0);
        check_eq("rst_score", bus.score, 0);
        rst = 1'b0;

        // Free running game with no spawns accepted.
        repeat (100) begin drive(0, 1, 0, 0, 0, 110); cycle(); end
        check_eq("run100_score", bus.score, 10);
        check_eq("run100_valid", bus.obsValid, 0);
        check_eq("run100_kill", bus.kill, 0);

        // Handshake: gen holds until create_obs, slot0 loads at the spawn column.
        run_until_gen(110);
        check_eq("gen_rise", bus.gen, 1);
        repeat (5) begin
            drive(0, 1, 0, 0, 0, 110); cycle();
            check_eq("gen_hold", bus.gen, 1);
        end
        drive(0, 1, 0, 1, 0, 110); cycle();
        check_eq("spawn_valid0", bus.obsValid[0], 1);
        check_eq("spawn_x0", bus.obsX0, 639);
        check_eq("spawn_gen_low", bus.gen, 0);

        // Grounded dino is hit; kill lags the overlap by one clock and sticks.
        for (int n = 0; n < 4000 && m_x[0] != 59; n++) begin drive(0, 1, 0, 0, 0, 110); cycle(); end
        check_eq("reach_x59", bus.obsX0, 59);
        check_eq("kill_pre", bus.kill, 0);
        drive(0, 1, 0, 0, 0, 110); cycle();
        check_eq("kill_set", bus.kill, 1);
        for (int n = 0; n < 400 && m_v[0]; n++) begin drive(0, 1, 0, 0, 0, 110); cycle(); end
        check_eq("expire_valid0", bus.obsValid[0], 0);
        check_eq("expire_x0", bus.obsX0, 0);
        check_eq("kill_sticky", bus.kill, 1);

        // Same pass with the dino in the air: no collision.
        drive(1, 0, 0, 0, 0, 80); cycle();
        check_eq("rg_kill", bus.kill, 0);
        spawn(80);
        for (int n = 0; n < 4000 && m_v[0]; n++) begin drive(0, 1, 0, 0, 0, 80); cycle(); end
        check_eq("jump_expire", bus.obsValid[0], 0);
        check_eq("kill_jump", bus.kill, 0);

        // Pause freezes everything visible.
        spawn(80);
        repeat (37) begin drive(0, 0, 1, 0, 0, 80); cycle(); end
        sv_score = m_score; sv_x0 = m_x[0]; sv_x1 = m_x[1]; sv_v = m_v[1] * 2 + m_v[0];
        repeat (50) begin drive(0, 0, 0, 0, 1, 110); cycle(); end
        check_eq("pause_score", bus.score, 64'(sv_score));
        check_eq("pause_x0", bus.obsX0, 64'(sv_x0));
        check_eq("pause_x1", bus.obsX1, 64'(sv_x1));
        check_eq("pause_valid", bus.obsValid, 64'(sv_v));
        repeat (30) begin drive(0, 1, 0, 0, 0, 80); cycle(); end

        // Fill both slots until a collision, then restart the game.
        for (int n = 0; n < 9000 && !(m_kill && m_v[0] && m_v[1]); n++) begin
            drive(0, 1, 0, m_gen, 0, 110); cycle();
        end
        check_eq("full_kill", bus.kill, 1);
        check_eq("full_valid", bus.obsValid, 3);
        drive(1, 1, 0, 1, 0, 110); cycle();
        check_eq("rg_kill2", bus.kill, 0);
        check_eq("rg_valid", bus.obsValid, 0);
        check_eq("rg_score", bus.score, 0);
        check_eq("rg_gen", bus.gen, 0);

        // Reset during an open handshake drops gen without loading.
        run_until_gen(110);
        check_eq("gen_before_rst", bus.gen, 1);
        rst = 1'b1; drive(0, 1, 0, 1, 0, 110); cycle();
        rst = 1'b0;
        check_eq("rst_mid_gen", bus.gen, 0);
        check_eq("rst_mid_valid", bus.obsValid, 0);

        // Random strobes, heights, occasional restarts.
        for (int n = 0; n < 8000; n++) begin
            sel = int'($urandom_range(0, 9));
            co  = (sel == 7) || (m_gen && $urandom_range(0, 3) == 0);
            h   = ($urandom_range(0, 1) == 1) ? 110 : int'($urandom_range(40, 110));
            rst = ($urandom_range(0, 2999) == 0);
            drive($urandom_range(0, 1499) == 0, sel <= 5, sel == 6, co, sel == 8, h);
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obstacle_engine.md
OBSTACLE_ENGINE -- requirements
Module: obstacle_engine

Interface
REQ-001 CLOCK_FREQUENCY, 25000000, system clock rate in Hz.
REQ-002 SCROLL_HZ, 60, scroll tick rate; TICK_DIV = CLOCK_FREQUENCY/SCROLL_HZ.
REQ-003 SPEED, 2, pixels moved per tick; SPAWN_X, 639, spawn column; MIN_GAP, 40, minimum ticks between spawns.
REQ-004 DINO_X0/DINO_X1, 40/60, dino hitbox columns; OBS_W, 10; OBS_TOP, 90, obstacle top row (ground row is 110).
REQ-005 Clock  in  1  system clock; all logic is on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 reset_game, ld_game, calc_jump, create_obs, ld_pause  in  1 each  FSM state strobes.
REQ-008 height  in  16  dino top row; 110 means grounded, smaller means higher.
REQ-009 gen  out  1  spawn request to the FSM.
REQ-010 kill  out  1  collision flag to the FSM.
REQ-011 obsValid  out  2  per-slot occupancy.
REQ-012 obsX0, obsX1  out  10 each  left column of slots 0 and 1.
REQ-013 score  out  16  ticks survived.

Function
REQ-014 The block SHALL be running when ld_game or calc_jump or create_obs is 1; it SHALL hold all state otherwise, including during ld_pause.
REQ-015 The tick counter SHALL count 0..TICK_DIV-1 only while running, wrap to 0, and pulse tick for one cycle at TICK_DIV-1.
REQ-016 On each tick, every valid slot with x >= SPEED SHALL move to x-SPEED; a valid slot with x < SPEED SHALL clear to valid=0 and x=0.
REQ-017 On each tick, score SHALL increment, saturating at 16'hFFFF.
REQ-018 A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1) SHALL advance every clock regardless of running, and SHALL never be loaded with zero.
REQ-019 gap SHALL increment on each tick, saturating at MIN_GAP.
REQ-020 gen SHALL rise the cycle after a tick at which all of these hold: gap == MIN_GAP, lfsr[3:0] == 0, at least one slot is free, and gen is 0.
REQ-021 Handshake: gen SHALL stay 1 until a cycle with create_obs=1; that cycle SHALL load the lowest free slot with x=SPAWN_X and valid=1, reset gap to 0, and gen SHALL be 0 on the next cycle.
REQ-022 If create_obs coincides with a tick, the new slot SHALL NOT be decremented that cycle; other slots SHALL still move.
REQ-023 If create_obs=1 while gen=0, the block SHALL do nothing.
REQ-024 If both slots are full, gen SHALL NOT assert; a slot freed on a tick SHALL make spawning eligible from the next tick.
REQ-025 A slot SHALL collide when valid, x <= DINO_X1, x+OBS_W-1 >= DINO_X0, and height > OBS_TOP; the x+OBS_W-1 sum SHALL be computed 11 bits wide.
REQ-026 kill SHALL be registered (one cycle after the collision condition, evaluated only while running) and sticky until reset or reset_game.
REQ-027 reset_game SHALL clear slots, score, gap, tick counter, gen and kill in one cycle, and SHALL take priority over every other event in that cycle; it SHALL leave the LFSR untouched.

Reset
REQ-028 reset SHALL take priority over reset_game; next cycle gen=0, kill=0, obsValid=2'b00, obsX0=obsX1=0, score=0, gap=0, tick counter=0, LFSR=16'hACE1.
REQ-029 Asserting reset mid-handshake (gen=1) SHALL drop gen with no slot loaded.

Verification (CLOCK_FREQUENCY=600, SCROLL_HZ=60 gives TICK_DIV=10; MIN_GAP=2 for the bench)
REQ-030 ld_game=1 for 100 cycles with no spawn -> score=10, obsValid=00, kill=0.
REQ-031 Force the spawn condition, hold create_obs=0 for 5 cycles, then pulse it -> gen holds 1 until that cycle; slot0 x=639, valid=1; gen=0 next cycle.
REQ-032 Slot0 at x=62, height=110, running -> after the tick to x=60, kill=1 one cycle later and stays 1; height=80 in the same scenario -> kill=0.
REQ-033 Slot0 at x=1, tick -> obsValid[0]=0, obsX0=0.
REQ-034 ld_pause=1 for 50 cycles mid-game -> score, obsX0/obsX1, gap and tick counter unchanged.
REQ-035 reset_game with kill=1 and both slots full -> next cycle kill=0, obsValid=00, score=0, LFSR still advancing.
